// File: rtl/led_pattern.sv
`default_nettype none
// ============================================================================
// led_pattern : LED pattern sequencer (rotate/bounce/bar) with PWM dimming
// Revision    : 1.0
// ============================================================================
module led_pattern #(
  parameter int WIDTH  = 16,
  parameter int PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             step,
  input  logic [1:0]       mode,
  input  logic [3:0]       duty,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic             dir
);

  localparam int             CW         = $clog2(PERIOD);
  localparam logic [CW-1:0]  c_cnt_last = CW'(PERIOD - 1);
  localparam logic [CW-1:0]  c_cnt_one  = CW'(1);
  localparam logic [WIDTH-1:0] c_pat_init = {{(WIDTH-1){1'b0}}, 1'b1};

  localparam logic [1:0] c_mode_rol    = 2'd0;
  localparam logic [1:0] c_mode_ror    = 2'd1;
  localparam logic [1:0] c_mode_bounce = 2'd2;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_pat;
  logic [WIDTH-1:0] r_led;
  logic [3:0]       r_pwm;
  logic [1:0]       r_mode_q;
  logic             r_step_q;
  logic             r_tick;
  logic             r_dir;

  logic             w_mode_chg;
  logic             w_adv;
  logic             w_on;
  logic [WIDTH-1:0] w_pat_nxt;
  logic             w_dir_nxt;

  assign w_mode_chg = (mode != r_mode_q);
  // A mode switch swallows any advance landing in the same cycle.
  assign w_adv = !w_mode_chg &&
                 ((en && (r_cnt == c_cnt_last)) || (!en && step && !r_step_q));
  assign w_on  = (duty == 4'hF) || (r_pwm < duty);

  always_comb begin
    w_pat_nxt = r_pat;
    w_dir_nxt = r_dir;
    case (mode)
      c_mode_rol: w_pat_nxt = {r_pat[WIDTH-2:0], r_pat[WIDTH-1]};
      c_mode_ror: w_pat_nxt = {r_pat[0], r_pat[WIDTH-1:1]};
      c_mode_bounce: begin
        // Reversal happens on the advance that would fall off the end.
        if (!r_dir) begin
          if (r_pat[WIDTH-1]) begin
            w_dir_nxt = 1'b1;
            w_pat_nxt = r_pat >> 1;
          end else begin
            w_pat_nxt = r_pat << 1;
          end
        end else begin
          if (r_pat[0]) begin
            w_dir_nxt = 1'b0;
            w_pat_nxt = r_pat << 1;
          end else begin
            w_pat_nxt = r_pat >> 1;
          end
        end
      end
      default: w_pat_nxt = (&r_pat) ? c_pat_init : {r_pat[WIDTH-2:0], 1'b1};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_pat    <= c_pat_init;
      r_led    <= '0;
      r_pwm    <= 4'd0;
      r_mode_q <= 2'd0;
      r_step_q <= 1'b0;
      r_tick   <= 1'b0;
      r_dir    <= 1'b0;
    end else begin
      r_step_q <= step;
      r_mode_q <= mode;
      r_pwm    <= r_pwm + 4'd1;
      r_tick   <= w_adv;
      r_led    <= r_pat & {WIDTH{w_on}};
      if (w_mode_chg) begin
        r_pat <= c_pat_init;
        r_dir <= 1'b0;
        r_cnt <= '0;
      end else begin
        if (en) begin
          r_cnt <= (r_cnt == c_cnt_last) ? '0 : r_cnt + c_cnt_one;
        end
        if (w_adv) begin
          r_pat <= w_pat_nxt;
          r_dir <= w_dir_nxt;
        end
      end
    end
  end

  assign led  = r_led;
  assign tick = r_tick;
  assign dir  = r_dir;

endmodule
`default_nettype wire
